// File: rtl/multimem_dbuf.sv
// multimem_dbuf: double-buffered frame store; byte-wide writes go to the back buffer,
// wide parallel reads scan the front buffer, and buffers flip on a frame-aligned swap handshake.
module multimem_dbuf #(
    parameter int PIXEL_WIDTH      = 64,
    parameter int PIXEL_HEIGHT     = 32,
    parameter int PIXEL_HALFHEIGHT = 16,
    parameter int BYTES_PER_PIXEL  = 2,
    parameter int DOUBLE_BUFFER    = 1,
    localparam int SLICES = PIXEL_HEIGHT / PIXEL_HALFHEIGHT,
    localparam int LANE_W = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1,
    localparam int RD_AW  = $clog2(PIXEL_HALFHEIGHT * PIXEL_WIDTH),
    localparam int WR_AW  = $clog2(SLICES) + RD_AW + LANE_W
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              wr_en,
    input  logic [WR_AW-1:0]                  wr_addr,
    input  logic [7:0]                        wr_data,
    input  logic                              rd_en,
    input  logic [RD_AW-1:0]                  rd_addr,
    output logic [SLICES*BYTES_PER_PIXEL*8-1:0] rd_data,
    output logic                              rd_valid,
    input  logic                              swap_req,
    input  logic                              frame_end,
    output logic                              swap_pending,
    output logic                              swap_ack,
    output logic                              front_sel,
    output logic                              wr_err
);
    localparam int NBUF  = (DOUBLE_BUFFER != 0) ? 2 : 1;
    localparam int LANES = SLICES * BYTES_PER_PIXEL;
    localparam int NB    = NBUF * LANES;
    localparam int BW    = (NB > 1) ? $clog2(NB) : 1;
    localparam int SW    = (SLICES > 1) ? $clog2(SLICES) : 1;

    typedef enum logic {IDLE, PENDING} state_t;

    state_t             state_q;
    logic               swap_ack_q, front_sel_q, wr_err_q, rd_valid_q;
    logic [LANES*8-1:0] rd_data_q;
    logic [7:0]         mem_q [NB][2**RD_AW];

    logic               back, front_idx, lane_ok, wr_ok;
    logic [SW-1:0]      wr_slice;
    logic [LANE_W-1:0]  wr_lane;
    logic [RD_AW-1:0]   wr_row;
    logic [BW-1:0]      wr_bank;

    assign front_idx = (DOUBLE_BUFFER != 0) ? front_sel_q : 1'b0;
    assign back      = (DOUBLE_BUFFER != 0) ? ~front_sel_q : 1'b0;
    assign wr_slice  = SW'(wr_addr >> (RD_AW + LANE_W));
    assign wr_row    = wr_addr[RD_AW+LANE_W-1:LANE_W];
    assign wr_lane   = wr_addr[LANE_W-1:0];
    assign lane_ok   = 32'(wr_lane) < BYTES_PER_PIXEL;
    assign wr_ok     = wr_en && lane_ok && (32'(wr_slice) < SLICES);
    assign wr_bank   = BW'((32'(back) * SLICES + 32'(wr_slice)) * BYTES_PER_PIXEL + 32'(wr_lane));

    // Sub-bank index is {buffer, slice, lane}; contents survive reset.
    always_ff @(posedge clk)
        if (wr_ok)
            mem_q[wr_bank][wr_row] <= wr_data;

    // Nonblocking reads against the same memory give read-first collision behaviour.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en)
                for (int i = 0; i < LANES; i++)
                    rd_data_q[i*8 +: 8] <= mem_q[BW'(32'(front_idx) * LANES + i)][rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            swap_ack_q  <= 1'b0;
            front_sel_q <= 1'b0;
        end else begin
            swap_ack_q <= 1'b0;
            if (state_q == IDLE) begin
                if (swap_req)
                    state_q <= PENDING;
            end else if (frame_end) begin
                state_q    <= IDLE;
                swap_ack_q <= 1'b1;
                if (DOUBLE_BUFFER != 0)
                    front_sel_q <= ~front_sel_q;
            end
        end
    end

    always_ff @(posedge clk)
        if (reset)
            wr_err_q <= 1'b0;
        else if (wr_en && !lane_ok)
            wr_err_q <= 1'b1;

    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign swap_pending = state_q == PENDING;
    assign swap_ack     = swap_ack_q;
    assign front_sel    = front_sel_q;
    assign wr_err       = wr_err_q;
endmodule

// File: tb/tb_multimem_dbuf.sv
// tb_multimem_dbuf: three configurations (single buffer, default double buffer, three lanes)
// checked every cycle against a frame-level model, plus hand-computed literal expectations.
module tb_multimem_dbuf;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we[3], re[3], sr[3], fe[3];
    logic [12:0] wa[3];
    logic [7:0]  wd[3];
    logic [9:0]  ra[3];
    logic        rv[3], pend[3], ack[3], fs[3], werr[3];
    logic [31:0] rd0, rd1;
    logic [47:0] rd3;
    logic [47:0] rdg[3];

    int checks = 0;
    int passes = 0;

    int dbp[3]  = '{0, 1, 1};
    int bpp[3]  = '{2, 2, 3};
    int lwp[3]  = '{1, 1, 2};

    logic [7:0]  mm[int];
    logic        mfront[3], mpend[3], mack[3], mwerr[3], mvalid[3];
    logic [47:0] mrd[3];
    logic [5:0]  mknown[3];

    always #5 clk = ~clk;

    multimem_dbuf #(.DOUBLE_BUFFER(0)) u0 (
        .clk(clk), .reset(rst), .wr_en(we[0]), .wr_addr(wa[0][11:0]), .wr_data(wd[0]),
        .rd_en(re[0]), .rd_addr(ra[0]), .rd_data(rd0), .rd_valid(rv[0]),
        .swap_req(sr[0]), .frame_end(fe[0]), .swap_pending(pend[0]), .swap_ack(ack[0]),
        .front_sel(fs[0]), .wr_err(werr[0]));

    multimem_dbuf u1 (
        .clk(clk), .reset(rst), .wr_en(we[1]), .wr_addr(wa[1][11:0]), .wr_data(wd[1]),
        .rd_en(re[1]), .rd_addr(ra[1]), .rd_data(rd1), .rd_valid(rv[1]),
        .swap_req(sr[1]), .frame_end(fe[1]), .swap_pending(pend[1]), .swap_ack(ack[1]),
        .front_sel(fs[1]), .wr_err(werr[1]));

    multimem_dbuf #(.BYTES_PER_PIXEL(3)) u3 (
        .clk(clk), .reset(rst), .wr_en(we[2]), .wr_addr(wa[2]), .wr_data(wd[2]),
        .rd_en(re[2]), .rd_addr(ra[2]), .rd_data(rd3), .rd_valid(rv[2]),
        .swap_req(sr[2]), .frame_end(fe[2]), .swap_pending(pend[2]), .swap_ack(ack[2]),
        .front_sel(fs[2]), .wr_err(werr[2]));

    assign rdg[0] = {16'h0, rd0};
    assign rdg[1] = {16'h0, rd1};
    assign rdg[2] = rd3;

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    function automatic int kk(int k, int b, int s, int l, int a);
        return ((((k * 2 + b) * 2 + s) * 4 + l) * 1024) + a;
    endfunction

    // Model: one frame per buffer as a sparse byte map; unwritten bytes are not compared.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                mfront[k] = 0; mpend[k] = 0; mack[k] = 0; mwerr[k] = 0;
                mvalid[k] = 0; mrd[k] = '0; mknown[k] = '1;
            end else begin
                int fb, lane, row, sl;
                fb = int'(mfront[k]);
                if (re[k])
                    for (int s = 0; s < 2; s++)
                        for (int l = 0; l < bpp[k]; l++) begin
                            int key, bi;
                            key = kk(k, fb, s, l, int'(ra[k]));
                            bi = s * bpp[k] + l;
                            if (mm.exists(key)) begin
                                mrd[k][bi*8 +: 8] = mm[key];
                                mknown[k][bi] = 1'b1;
                            end else mknown[k][bi] = 1'b0;
                        end
                mvalid[k] = re[k];
                if (we[k]) begin
                    lane = int'(wa[k]) % (1 << lwp[k]);
                    row  = (int'(wa[k]) >> lwp[k]) % 1024;
                    sl   = (int'(wa[k]) >> (lwp[k] + 10)) % 2;
                    if (lane >= bpp[k]) mwerr[k] = 1;
                    else mm[kk(k, (dbp[k] != 0) ? 1 - fb : 0, sl, lane, row)] = wd[k];
                end
                mack[k] = 0;
                if (mpend[k] && fe[k]) begin
                    mpend[k] = 0; mack[k] = 1;
                    if (dbp[k] != 0) mfront[k] = !mfront[k];
                end else if (!mpend[k] && sr[k]) mpend[k] = 1;
            end
            chk($sformatf("u%0d_pending", k), pend[k], mpend[k]);
            chk($sformatf("u%0d_ack", k), ack[k], mack[k]);
            chk($sformatf("u%0d_front", k), fs[k], mfront[k]);
            chk($sformatf("u%0d_wr_err", k), werr[k], mwerr[k]);
            chk($sformatf("u%0d_rd_valid", k), rv[k], mvalid[k]);
            for (int b = 0; b < 2 * bpp[k]; b++)
                if (mknown[k][b]) chk($sformatf("u%0d_rd_byte%0d", k, b), rdg[k][b*8 +: 8], mrd[k][b*8 +: 8]);
        end
    end

    task automatic tick(); @(negedge clk); endtask

    task automatic wr(int k, logic [12:0] a, logic [7:0] d);
        we[k] = 1; wa[k] = a; wd[k] = d; tick(); we[k] = 0;
    endtask

    task automatic rd(int k, logic [9:0] a);
        re[k] = 1; ra[k] = a; tick(); re[k] = 0;
    endtask

    task automatic ev(int k, logic s, logic f);
        sr[k] = s; fe[k] = f; tick(); sr[k] = 0; fe[k] = 0;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            we[k] = 0; re[k] = 0; sr[k] = 0; fe[k] = 0; wa[k] = '0; wd[k] = '0; ra[k] = '0;
        end
        repeat (2) tick();
        rst = 0;
        chk("reset_rd_data", rd1, 32'h0);
        chk("reset_front", fs[1], 1'b0);

        wr(0, 13'hFFF, 8'h41);
        wr(0, 13'hFFE, 8'h42);
        rd(0, 10'h3FF);
        chk("sb_readback", rd0[31:16], 16'h4142);
        chk("sb_rd_valid", rv[0], 1'b1);
        tick();
        chk("sb_valid_drop", rv[0], 1'b0);
        chk("sb_hold", rd0[31:16], 16'h4142);
        wr(0, 13'h7FF, 8'h5A);
        rd(0, 10'h3FF);
        chk("slice_byte1", rd0[15:8], 8'h5A);
        chk("slice_byte3", rd0[31:24], 8'h41);

        wr(0, 13'h002, 8'h11);
        we[0] = 1; wa[0] = 13'h002; wd[0] = 8'h44; re[0] = 1; ra[0] = 10'h001;
        tick();
        we[0] = 0; re[0] = 0;
        chk("collide_old", rd0[7:0], 8'h11);
        rd(0, 10'h001);
        chk("collide_new", rd0[7:0], 8'h44);

        wr(1, 13'hFFF, 8'h43);
        rd(1, 10'h3FF);
        chk("db_isolated", rd1[31:24] != 8'h43, 1'b1);
        ev(1, 1, 0);
        chk("db_pending", pend[1], 1'b1);
        ev(1, 0, 1);
        chk("db_ack", ack[1], 1'b1);
        chk("db_front", fs[1], 1'b1);
        chk("db_pending_clr", pend[1], 1'b0);
        rd(1, 10'h3FF);
        chk("db_flipped", rd1[31:24], 8'h43);

        ev(1, 1, 1);
        chk("simul_pending", pend[1], 1'b1);
        chk("simul_no_flip", fs[1], 1'b1);
        chk("simul_no_ack", ack[1], 1'b0);
        fe[1] = 1; we[1] = 1; wa[1] = 13'h000; wd[1] = 8'h77;
        tick();
        fe[1] = 0; we[1] = 0;
        chk("flip2_ack", ack[1], 1'b1);
        chk("flip2_front", fs[1], 1'b0);
        rd(1, 10'h000);
        chk("flip_cycle_write", rd1[7:0], 8'h77);

        wr(2, 13'h1FFE, 8'h5C);
        ev(2, 1, 0);
        ev(2, 0, 1);
        rd(2, 10'h3FF);
        chk("l3_lane2", rd3[47:40], 8'h5C);
        wr(2, 13'h0003, 8'h99);
        chk("l3_wr_err", werr[2], 1'b1);
        ev(2, 1, 0);
        chk("l3_pending", pend[2], 1'b1);
        rst = 1; tick(); rst = 0;
        chk("rst_outputs", {pend[2], ack[2], fs[2], werr[2], rv[2]}, 5'b0);
        chk("rst_rd_data", rd3, 48'h0);
        ev(2, 0, 1);
        chk("rst_cancel_ack", ack[2], 1'b0);
        chk("rst_cancel_pend", pend[2], 1'b0);
        repeat (3) tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
